div_ctrl: RTL
=============

Name: div_ctrl

Overview:
- Sequencing controller between the EX stage and the multicycle divider for DIV/DIVU.
- Latches operands and drives the divider start/cancel handshake.
- Holds the pipeline with a stall request until the divider's 64-bit result is ready, then delivers the quotient and remainder for the HI/LO write.
- Handles pipeline flush mid-divide and divider drain so back-to-back divides never collide with the divider's end state.

Parameters:
CANCEL_DRAIN, 3, cycles start is held low after a cancel before IDLE may accept again
TIMEOUT_CYCLES, 40, watchdog limit in BUSY (used only with DIV_CTRL_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
op_valid_i  in  1  EX stage holds a DIV/DIVU
op_signed_i  in  1  1=DIV, 0=DIVU
op_a_i  in  32  dividend (rs)
op_b_i  in  32  divisor (rt)
flush_i  in  1  pipeline flush/exception; kill the in-flight divide
stall_req_o  out  1  request EX-stage stall
result_valid_o  out  1  one-cycle pulse; hi_o/lo_o valid for HI/LO write
hi_o  out  32  remainder
lo_o  out  32  quotient
dbz_o  out  1  divide-by-zero flag, valid with result_valid_o
div_start_o  out  1  to divider start
div_signed_o  out  1  to divider signed select
div_dividend_o  out  32  to divider dividend
div_divider_o  out  32  to divider divisor
div_cancel_o  out  1  to divider cancel
div_result_i  in  64  from divider: {remainder, quotient}
div_success_i  in  1  from divider: result valid; held while start stays high
timeout_o  out  1  sticky watchdog flag (present only with DIV_CTRL_TIMEOUT_EN)

Behaviour:
- Reset: IDLE.
  - All outputs are 0.
  - Operand, hi, lo, dbz and drain-counter registers are 0.
  - Reset mid-divide abandons the operation. The divider shares rst.
- States: IDLE, BUSY, DONE, DRAIN.
- IDLE:
  - op_valid_i=1 and flush_i=0: latch op_signed_i, op_a_i and op_b_i into registers, latch dbz = (op_b_i==0), go to BUSY.
  - stall_req_o = op_valid_i in this cycle.
- BUSY:
  - div_start_o=1. div_signed_o, div_dividend_o and div_divider_o come from the latched registers and stay stable for the whole operation.
  - stall_req_o=1.
  - div_success_i=1 and flush_i=0: capture hi = div_result_i[63:32] and lo = div_result_i[31:0], go to DONE.
  - flush_i=1: div_cancel_o=1 combinationally and div_start_o=0 in the same cycle. Load drain counter = CANCEL_DRAIN and go to DRAIN. Any coincident div_success_i is discarded; flush wins.
- DONE, exactly 1 cycle:
  - result_valid_o = ~flush_i; stall_req_o=0; div_start_o=0.
  - hi_o, lo_o and dbz_o are driven from the registers and hold until the next capture.
  - Load drain counter = 1 and go to DRAIN.
- DRAIN:
  - div_start_o=0; stall_req_o = op_valid_i.
  - The counter decrements each cycle.
  - Go to IDLE when the counter reaches 0 and div_success_i=0.
  - This guarantees the divider has left its end/zero states before the next start.
- Divide by zero: the divider returns result 0 with success. The controller passes hi=lo=0 with dbz_o=1 and keeps the MIPS-unpredictable result as 0.
- Latency: result_valid_o rises the cycle after div_success_i is sampled in BUSY. The earliest next-op start is 2 cycles after DONE.
- div_cancel_o is asserted only in BUSY with flush_i. It is never asserted in IDLE, DONE or DRAIN.
- A flush while in IDLE or DRAIN has no effect except suppressing acceptance in IDLE.

Optional Feature:
DIV_CTRL_TIMEOUT_EN
- Defined:
  - A 6-bit cycle counter clears on BUSY entry and increments each BUSY cycle.
  - If it reaches TIMEOUT_CYCLES without div_success_i: pulse div_cancel_o, set timeout_o (sticky until rst), and complete through DONE with result_valid_o=1, hi=lo=0 and dbz_o=0.
  - Then DRAIN with CANCEL_DRAIN.
- Undefined: no counter, no timeout_o port; BUSY waits indefinitely.

Test Plan:
- DIVU 100/7: op_valid_i held -> stall_req_o high until DONE; lo_o=14, hi_o=2, dbz_o=0, single result_valid_o pulse.
- DIV -7/2 (0xFFFFFFF9, 2) -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF; div_signed_o=1 throughout BUSY.
- DIVU 5/0 -> result_valid_o pulse with hi_o=lo_o=0, dbz_o=1; no div_cancel_o.
- flush_i on 10th BUSY cycle -> div_cancel_o one cycle, no result_valid_o, IDLE after 3 DRAIN cycles; a new DIVU 9/3 then gives lo_o=3, hi_o=0.
- Back-to-back DIVU 50/5 then 64/8 with op_valid_i continuous -> second op starts only after DRAIN; lo_o=10 then 8, two distinct result_valid_o pulses.
- rst asserted mid-BUSY -> next cycle all outputs 0, state IDLE; subsequent DIVU 1/1 gives lo_o=1, hi_o=0.

Source files
------------

// File: rtl/div_ctrl.sv
// div_ctrl: sequences DIV/DIVU between the EX stage and the multicycle divider.
// Optional BUSY watchdog with sticky timeout_o is built when DIV_CTRL_TIMEOUT_EN is defined.
module div_ctrl #(
    parameter int unsigned CANCEL_DRAIN = 3
`ifdef DIV_CTRL_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYCLES = 40
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid_i,
    input  logic        op_signed_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    input  logic        flush_i,
    output logic        stall_req_o,
    output logic        result_valid_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        dbz_o,
    output logic        div_start_o,
    output logic        div_signed_o,
    output logic [31:0] div_dividend_o,
    output logic [31:0] div_divider_o,
    output logic        div_cancel_o,
    input  logic [63:0] div_result_i,
    input  logic        div_success_i
`ifdef DIV_CTRL_TIMEOUT_EN
    , output logic      timeout_o
`endif
);

    localparam int unsigned DRAIN_W = (CANCEL_DRAIN < 2) ? 1 : $clog2(CANCEL_DRAIN + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE, DRAIN} state_t;

    state_t               state_q, state_d;
    logic [DRAIN_W-1:0]   drain_q;
    logic                 signed_q;
    logic [31:0]          a_q, b_q, hi_q, lo_q;
    logic                 dbz_q;
    logic                 accept, capture;

`ifdef DIV_CTRL_TIMEOUT_EN
    localparam int unsigned TO_W = 6;
    logic [TO_W-1:0]      to_cnt_q;
    logic                 to_hit_q;
    logic                 timeout_q;
    logic                 to_fire;
    assign timeout_o = timeout_q;
`endif

    assign div_signed_o   = signed_q;
    assign div_dividend_o = a_q;
    assign div_divider_o  = b_q;
    assign hi_o           = hi_q;
    assign lo_o           = lo_q;
    assign dbz_o          = dbz_q;

    // Next state and handshake outputs; cancel/start react to flush in the same cycle.
    always_comb begin
        state_d        = state_q;
        stall_req_o    = 1'b0;
        div_start_o    = 1'b0;
        div_cancel_o   = 1'b0;
        result_valid_o = 1'b0;
        accept         = 1'b0;
        capture        = 1'b0;
`ifdef DIV_CTRL_TIMEOUT_EN
        to_fire        = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                stall_req_o = op_valid_i;
                if (op_valid_i && !flush_i) begin
                    accept  = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                stall_req_o = 1'b1;
                div_start_o = 1'b1;
                if (flush_i) begin
                    div_start_o  = 1'b0;
                    div_cancel_o = 1'b1;
                    state_d      = DRAIN;
                end else if (div_success_i) begin
                    capture = 1'b1;
                    state_d = DONE;
                end
`ifdef DIV_CTRL_TIMEOUT_EN
                else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    div_start_o  = 1'b0;
                    div_cancel_o = 1'b1;
                    to_fire      = 1'b1;
                    state_d      = DONE;
                end
`endif
            end
            DONE: begin
                result_valid_o = ~flush_i;
                state_d        = DRAIN;
            end
            DRAIN: begin
                stall_req_o = op_valid_i;
                // Leave only once the divider has dropped success, so a new start sees a clean divider.
                if ((drain_q <= DRAIN_W'(1)) && !div_success_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, operand latches, result capture and drain counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            drain_q  <= '0;
            signed_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            dbz_q    <= 1'b0;
`ifdef DIV_CTRL_TIMEOUT_EN
            to_cnt_q  <= '0;
            to_hit_q  <= 1'b0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                signed_q <= op_signed_i;
                a_q      <= op_a_i;
                b_q      <= op_b_i;
                dbz_q    <= (op_b_i == 32'd0);
            end
            if (capture) begin
                hi_q <= div_result_i[63:32];
                lo_q <= div_result_i[31:0];
            end
            case (state_q)
                BUSY: if (flush_i) drain_q <= DRAIN_W'(CANCEL_DRAIN);
`ifdef DIV_CTRL_TIMEOUT_EN
                DONE: drain_q <= to_hit_q ? DRAIN_W'(CANCEL_DRAIN) : DRAIN_W'(1);
`else
                DONE: drain_q <= DRAIN_W'(1);
`endif
                DRAIN: if (drain_q != '0) drain_q <= drain_q - DRAIN_W'(1);
                default: ;
            endcase
`ifdef DIV_CTRL_TIMEOUT_EN
            if (accept) begin
                to_cnt_q <= '0;
                to_hit_q <= 1'b0;
            end else if (state_q == BUSY) begin
                to_cnt_q <= to_cnt_q + TO_W'(1);
            end
            // Watchdog completes the op with a zero, non-dbz result.
            if (to_fire) begin
                hi_q      <= '0;
                lo_q      <= '0;
                dbz_q     <= 1'b0;
                to_hit_q  <= 1'b1;
                timeout_q <= 1'b1;
            end
`endif
        end
    end

endmodule
